// File: rtl/alu_read_mux_seq.sv
// alu_read_mux_seq: registered source selector feeding the ALU input bus.
// Register sources are read in one cycle. The RAM slot is fetched through a
// req/ack handshake that aborts with an error after TIMEOUT wait cycles.
module alu_read_mux_seq #(
  parameter int WIDTH   = 16,
  parameter int NSRC    = 8,
  parameter int SEL_W   = 3,
  parameter int RAM_SEL = 7,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_en,
  input  logic [SEL_W-1:0]      select,
  input  logic [NSRC*WIDTH-1:0] src_bus,
  input  logic [WIDTH-1:0]      ram_data,
  input  logic                  ram_ack,
  output logic                  ram_rd,
  output logic [WIDTH-1:0]      to_alus,
  output logic                  to_alus_valid,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic {
    IDLE,
    RAM_WAIT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       wait_cnt;
  logic [7:0]       wait_cnt_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             valid_nxt;
  logic             err_nxt;
  logic             ram_rd_nxt;
  logic [WIDTH-1:0] reg_val;
  logic             sel_illegal;
  logic             sel_ram;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  // Decode the select code into illegal / RAM / register source classes
  always_comb begin
    sel_illegal = (int'(select) >= NSRC);
    sel_ram     = (int'(select) == RAM_SEL);
  end

  // Register-source multiplexer; the RAM slot and illegal codes yield zero
  always_comb begin
    reg_val = '0;
    for (int i = 0; i < NSRC; i++) begin
      if ((int'(select) == i) && (i != RAM_SEL)) begin
        reg_val = src_bus[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and next-output logic; strobes default low, data holds
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    data_nxt     = to_alus;
    valid_nxt    = 1'b0;
    err_nxt      = 1'b0;
    ram_rd_nxt   = ram_rd;
    case (state)
      IDLE: begin
        if (rd_en) begin
          if (sel_illegal) begin
            data_nxt  = '0;
            valid_nxt = 1'b1;
            err_nxt   = 1'b1;
          end else if (sel_ram) begin
            ram_rd_nxt   = 1'b1;
            wait_cnt_nxt = '0;
            state_nxt    = RAM_WAIT;
          end else begin
            data_nxt  = reg_val;
            valid_nxt = 1'b1;
          end
        end
      end
      RAM_WAIT: begin
        if (ram_ack) begin
          data_nxt     = ram_data;
          valid_nxt    = 1'b1;
          ram_rd_nxt   = 1'b0;
          wait_cnt_nxt = '0;
          state_nxt    = IDLE;
        end else if (wait_cnt == LAST_WAIT) begin
          data_nxt     = '0;
          valid_nxt    = 1'b1;
          err_nxt      = 1'b1;
          ram_rd_nxt   = 1'b0;
          wait_cnt_nxt = '0;
          state_nxt    = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        ram_rd_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset_n
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      to_alus       <= '0;
      to_alus_valid <= 1'b0;
      err           <= 1'b0;
      ram_rd        <= 1'b0;
    end else begin
      state         <= state_nxt;
      wait_cnt      <= wait_cnt_nxt;
      to_alus       <= data_nxt;
      to_alus_valid <= valid_nxt;
      err           <= err_nxt;
      ram_rd        <= ram_rd_nxt;
    end
  end

  // busy mirrors the outstanding RAM request
  assign busy = ram_rd;

endmodule
